// File: rtl/scr1_accel_vec.sv
// Memory-mapped vector multiply accelerator on the SCR1 data-memory port.
// Optional done interrupt (port irq, CTRL.IE) is built when SCR1_ACCEL_VEC_IRQ_EN is defined.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_accel_vec_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_accel_vec
  import scr1_accel_vec_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int ELEM_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          dmem_req_ack,
  input  logic                          dmem_req,
  input  logic                          dmem_cmd,
  input  logic [1:0]                    dmem_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata,
  output logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata,
  output logic [1:0]                    dmem_resp
`ifdef SCR1_ACCEL_VEC_IRQ_EN
  ,
  output logic                          irq
`endif
);

  localparam int EPW    = 32 / ELEM_W;
  localparam int EPW_LG = (ELEM_W == 8) ? 2 : 1;
  localparam int N      = NWORDS * EPW;
  localparam int AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              r_state;
  type_scr1_mem_resp_e r_resp;
  logic [31:0]         r_rdata;
  logic [31:0]         r_a [NWORDS];
  logic [31:0]         r_b [NWORDS];
  logic [31:0]         r_c [NWORDS];
  logic [31:0]         r_acc;
  logic [15:0]         r_cnt;
  logic [6:0]          r_idx;
  logic                r_mode;
  logic                r_sat;
  logic                r_done;

  logic                w_ie;
  logic                w_busy;
  logic                w_idle;
  logic                w_wr;
  logic [6:0]          w_idx;
  logic [AW-1:0]       w_boff;
  logic                w_hit_a;
  logic                w_hit_b;
  logic                w_hit_c;
  logic [31:0]         w_wdata_rep;
  logic [31:0]         w_rword;
  logic [AW-1:0]       w_word;
  logic [EPW_LG-1:0]   w_sel;
  logic [4:0]          w_off;
  logic [ELEM_W-1:0]   w_a_el;
  logic [ELEM_W-1:0]   w_b_el;
  logic [2*ELEM_W-1:0] w_prod;
  logic [ELEM_W-1:0]   w_c_el;
  logic                w_last;
  logic                w_unused;

  assign dmem_req_ack = 1'b1;
  assign dmem_rdata   = r_rdata;
  assign dmem_resp    = r_resp;
  assign w_unused     = ^{dmem_addr[`SCR1_DMEM_AWIDTH-1:9]};

  assign w_busy = (r_state == ST_RUN);
  assign w_idle = (r_state == ST_IDLE);
  assign w_wr   = dmem_req && (dmem_cmd == SCR1_MEM_CMD_WR);

  // Bank decode: word index bits [6:4] select the bank, [3:0] the word within it.
  assign w_idx   = dmem_addr[8:2];
  assign w_boff  = w_idx[AW-1:0];
  assign w_hit_a = (w_idx[6:4] == 3'd1) && ({1'b0, w_idx[3:0]} < 5'(NWORDS));
  assign w_hit_b = (w_idx[6:4] == 3'd2) && ({1'b0, w_idx[3:0]} < 5'(NWORDS));
  assign w_hit_c = (w_idx[6:4] == 3'd3) && ({1'b0, w_idx[3:0]} < 5'(NWORDS));

  always_comb begin
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:  w_wdata_rep = {4{dmem_wdata[7:0]}};
      SCR1_MEM_WIDTH_HWORD: w_wdata_rep = {2{dmem_wdata[15:0]}};
      default:              w_wdata_rep = dmem_wdata;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_rword = '0;
    if (w_idx == 7'd0)      w_rword = {r_done, w_busy, 26'd0, w_ie, r_sat, r_mode, 1'b0};
    else if (w_idx == 7'd1) w_rword = {16'd0, r_cnt};
    else if (w_idx == 7'd2) w_rword = r_acc;
    else if (w_hit_a)       w_rword = r_a[w_boff];
    else if (w_hit_b)       w_rword = r_b[w_boff];
    else if (w_hit_c)       w_rword = r_c[w_boff];
  end

  // Element datapath: element r_idx lives in word r_idx/EPW, LSB-first within the word.
  assign w_word = r_idx[AW+EPW_LG-1:EPW_LG];
  assign w_sel  = r_idx[EPW_LG-1:0];
  assign w_off  = 5'(w_sel) * 5'(ELEM_W);
  assign w_a_el = r_a[w_word][w_off +: ELEM_W];
  assign w_b_el = r_b[w_word][w_off +: ELEM_W];
  assign w_prod = {{ELEM_W{1'b0}}, w_a_el} * {{ELEM_W{1'b0}}, w_b_el};
  assign w_c_el = (r_sat && (|w_prod[2*ELEM_W-1:ELEM_W])) ? {ELEM_W{1'b1}} : w_prod[ELEM_W-1:0];
  assign w_last = (r_idx == 7'(N - 1));

`ifdef SCR1_ACCEL_VEC_IRQ_EN
  logic r_ie;
  logic r_irq;
  assign w_ie = r_ie;
  assign irq  = r_irq;
`else
  assign w_ie = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_resp  <= SCR1_MEM_RESP_NOTRDY;
      r_rdata <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_mode  <= 1'b0;
      r_sat   <= 1'b0;
      r_done  <= 1'b0;
      // NOTE: the banks are flops, not RAM, because reset must clear C and ACC even mid-operation.
      for (int i = 0; i < NWORDS; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_c[i] <= '0;
      end
`ifdef SCR1_ACCEL_VEC_IRQ_EN
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
`endif
    end else begin
      r_resp  <= dmem_req ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
      r_rdata <= (dmem_req && !w_wr) ? (w_rword >> {dmem_addr[1:0], 3'b000}) : '0;

      // Register file writes only land while idle; a busy engine owns A, B and CTRL.
      if (w_wr && w_idle) begin
        if (w_hit_a) r_a[w_boff] <= w_wdata_rep;
        if (w_hit_b) r_b[w_boff] <= w_wdata_rep;
        if (w_idx == 7'd0) begin
          r_mode <= w_wdata_rep[1];
          r_sat  <= w_wdata_rep[2];
`ifdef SCR1_ACCEL_VEC_IRQ_EN
          r_ie   <= w_wdata_rep[3];
`endif
          if (w_wdata_rep[0]) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            if (w_wdata_rep[1]) r_acc <= '0;
          end else if (w_wdata_rep[31]) begin
            r_done <= 1'b0;
          end
        end
      end

      if (r_state == ST_RUN) begin
        if (r_mode) r_acc <= r_acc + 32'(w_prod);
        else        r_c[w_word][w_off +: ELEM_W] <= w_c_el;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        if (w_last) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_idx <= r_idx + 7'd1;
        end
      end

`ifdef SCR1_ACCEL_VEC_IRQ_EN
      r_irq <= r_done & r_ie;
`endif
    end
  end

endmodule
